ota_bitstream_decimator: RTL and testbench

Digital back-end for the gate-level OTA/comparator stage. It samples the comparator's asynchronous 1-bit output, synchronises it into the `clk` domain, and accumulates it over fixed windows of 2^WIN_LOG2 cycles. Each window produces a duty-cycle (ones count) word and a transition count. Results leave through a valid/ready output register with overrun detection, so a slow consumer never receives a torn result.

---
 rtl/ota_bitstream_decimator.sv | 190 +++++++++++++++++++
 tb/tb_ota_bitstream_decimator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ota_bitstream_decimator.sv
// Comparator bitstream decimator: synchronises cmp_in and, over fixed windows of 2^WIN_LOG2
// cycles, counts ones and transitions; results leave through a valid/ready register.
module ota_bitstream_decimator #(
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cmp_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] duty,
    output logic [OUT_W-1:0] edges,
    output logic             overrun,
    output logic             cmp_sync
);

    localparam int unsigned AccW = WIN_LOG2 + 1;
    localparam int unsigned ExtW = (AccW > OUT_W) ? AccW : OUT_W;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Clamp an accumulator value to the output word range, zero-extending when it is wider.
    function automatic logic [OUT_W-1:0] sat(input logic [AccW-1:0] v);
        logic [ExtW-1:0] ext;
        logic [ExtW-1:0] lim;
        ext = ExtW'(v);
        lim = ExtW'({OUT_W{1'b1}});
        if (ext > lim) begin
            return {OUT_W{1'b1}};
        end
        return ext[OUT_W-1:0];
    endfunction

    state_e              r_state;
    state_e              w_state_next;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_s_prev;
    logic [WIN_LOG2-1:0] r_wcnt;
    logic [AccW-1:0]     r_ones;
    logic [AccW-1:0]     r_edges;
    logic                r_valid;
    logic [OUT_W-1:0]    r_duty;
    logic [OUT_W-1:0]    r_edge_out;
    logic                r_overrun;

    logic                w_s;
    logic                w_accum;
    logic                w_clear;
    logic                w_last;
    logic                w_complete;
    logic                w_edge_inc;
    logic [AccW-1:0]     w_ones_fin;
    logic [AccW-1:0]     w_edges_fin;
    logic                w_xfer;
    logic                w_load;
    logic                w_drop;
    logic [WIN_LOG2-1:0] w_wcnt_next;
    logic [AccW-1:0]     w_ones_next;
    logic [AccW-1:0]     w_edges_next;
    logic                w_s_prev_next;
    logic                w_valid_next;
    logic [OUT_W-1:0]    w_duty_next;
    logic [OUT_W-1:0]    w_edge_out_next;
    logic                w_overrun_next;

    assign w_s = r_sync2;

    // The first ena-high edge is sample 0, so accumulation already happens while still in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accum      = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_clear = 1'b1;
                if (ena) begin
                    w_state_next = StRun;
                    w_accum      = 1'b1;
                    w_clear      = 1'b0;
                end
            end
            StRun: begin
                w_accum = 1'b1;
                if (!ena) begin
                    w_state_next = StIdle;
                    w_accum      = 1'b0;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_clear      = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_last      = (r_wcnt == {WIN_LOG2{1'b1}});
        w_complete  = w_accum && w_last;
        // Sample 0 of a window never counts an edge, so edges stay inside their window.
        w_edge_inc  = (r_wcnt != '0) && (w_s != r_s_prev);
        w_ones_fin  = r_ones + AccW'(w_s);
        w_edges_fin = r_edges + AccW'(w_edge_inc);

        w_wcnt_next   = r_wcnt;
        w_ones_next   = r_ones;
        w_edges_next  = r_edges;
        w_s_prev_next = r_s_prev;
        if (w_clear) begin
            w_wcnt_next  = '0;
            w_ones_next  = '0;
            w_edges_next = '0;
        end else if (w_accum) begin
            w_s_prev_next = w_s;
            if (w_last) begin
                w_wcnt_next  = '0;
                w_ones_next  = '0;
                w_edges_next = '0;
            end else begin
                w_wcnt_next  = r_wcnt + 1'b1;
                w_ones_next  = w_ones_fin;
                w_edges_next = w_edges_fin;
            end
        end
    end

    always_comb begin
        w_xfer = r_valid && out_ready;
        w_load = w_complete && (!r_valid || out_ready);
        w_drop = w_complete && r_valid && !out_ready;

        w_valid_next    = r_valid;
        w_duty_next     = r_duty;
        w_edge_out_next = r_edge_out;
        w_overrun_next  = r_overrun;
        if (w_load) begin
            w_valid_next    = 1'b1;
            w_duty_next     = sat(w_ones_fin);
            w_edge_out_next = sat(w_edges_fin);
        end else if (w_xfer) begin
            w_valid_next = 1'b0;
        end
        if (w_drop) begin
            w_overrun_next = 1'b1;
        end else if (w_xfer) begin
            w_overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_s_prev   <= 1'b0;
            r_wcnt     <= '0;
            r_ones     <= '0;
            r_edges    <= '0;
            r_valid    <= 1'b0;
            r_duty     <= '0;
            r_edge_out <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sync1    <= cmp_in;
            r_sync2    <= r_sync1;
            r_s_prev   <= w_s_prev_next;
            r_wcnt     <= w_wcnt_next;
            r_ones     <= w_ones_next;
            r_edges    <= w_edges_next;
            r_valid    <= w_valid_next;
            r_duty     <= w_duty_next;
            r_edge_out <= w_edge_out_next;
            r_overrun  <= w_overrun_next;
        end
    end

    assign out_valid = r_valid;
    assign duty      = r_duty;
    assign edges     = r_edge_out;
    assign overrun   = r_overrun;
    assign cmp_sync  = r_sync2;

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Directed bench for ota_bitstream_decimator (WIN_LOG2=8, OUT_W=8) with hand-computed results.
module tb_ota_bitstream_decimator;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       cmp_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] duty;
    logic [7:0] edges;
    logic       overrun;
    logic       cmp_sync;

    int n_tests = 0;
    int n_fail  = 0;
    int tc      = 0;
    bit sq_en   = 0;

    ota_bitstream_decimator #(
        .WIN_LOG2(8),
        .OUT_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .cmp_in   (cmp_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .duty     (duty),
        .edges    (edges),
        .overrun  (overrun),
        .cmp_sync (cmp_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Square wave is phased so its transitions land on window starts after the 2-flop delay.
    task automatic tick();
        if (sq_en) cmp_in = (((tc + 2) >> 2) & 1) != 0;
        @(posedge clk);
        #1;
        tc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ena   = 1'b0;
        sq_en = 0;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        ena       = 1'b0;
        cmp_in    = 1'b0;
        out_ready = 1'b1;
        ticks(2);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_duty", duty, 0);
        check_eq("rst_edges", edges, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_sync", cmp_sync, 0);
        rst = 1'b0;
        ticks(3);

        // Constant high, starting together with ena
        cmp_in = 1'b1;
        ena    = 1'b1;
        ticks(255);
        check_eq("const_no_early_valid", out_valid, 0);
        check_eq("const_sync", cmp_sync, 1);
        tick();
        check_eq("const_w1_valid", out_valid, 1);
        check_eq("const_w1_duty", duty, 254);
        check_eq("const_w1_edges", edges, 1);
        tick();
        check_eq("const_pulse_end", out_valid, 0);
        ticks(255);
        check_eq("const_w2_valid", out_valid, 1);
        check_eq("const_w2_duty", duty, 255);
        check_eq("const_w2_edges", edges, 0);

        // Square wave, period 8
        do_reset();
        out_ready = 1'b1;
        sq_en     = 1;
        ticks(3);
        while ((tc % 8) != 0) tick();
        ena = 1'b1;
        ticks(256);
        check_eq("sq_w1_valid", out_valid, 1);
        check_eq("sq_w1_duty", duty, 128);
        check_eq("sq_w1_edges", edges, 63);
        ticks(256);
        check_eq("sq_w2_valid", out_valid, 1);
        check_eq("sq_w2_duty", duty, 128);
        check_eq("sq_w2_edges", edges, 63);
        ena   = 1'b0;
        sq_en = 0;

        // Backpressure across two completions
        do_reset();
        cmp_in    = 1'b1;
        out_ready = 1'b0;
        ticks(3);
        ena = 1'b1;
        ticks(256);
        check_eq("bp_w1_valid", out_valid, 1);
        check_eq("bp_w1_duty", duty, 255);
        check_eq("bp_w1_overrun", overrun, 0);
        cmp_in = 1'b0;
        ticks(256);
        check_eq("bp_held_valid", out_valid, 1);
        check_eq("bp_held_duty", duty, 255);
        check_eq("bp_held_edges", edges, 0);
        check_eq("bp_overrun_set", overrun, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_xfer_valid", out_valid, 0);
        check_eq("bp_xfer_overrun", overrun, 0);

        // Transfer coinciding with completion
        do_reset();
        cmp_in    = 1'b0;
        out_ready = 1'b0;
        ticks(3);
        ena = 1'b1;
        ticks(256);
        check_eq("sim_w1_valid", out_valid, 1);
        check_eq("sim_w1_duty", duty, 0);
        cmp_in = 1'b1;
        ticks(255);
        check_eq("sim_pre_valid", out_valid, 1);
        check_eq("sim_pre_duty", duty, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("sim_valid", out_valid, 1);
        check_eq("sim_duty", duty, 254);
        check_eq("sim_edges", edges, 1);
        check_eq("sim_overrun", overrun, 0);

        // ena drop at window cycle 100, result still held
        ticks(100);
        ena = 1'b0;
        ticks(5);
        check_eq("drop_held_valid", out_valid, 1);
        check_eq("drop_held_duty", duty, 254);
        check_eq("drop_held_edges", edges, 1);
        check_eq("drop_overrun", overrun, 0);
        ena       = 1'b1;
        out_ready = 1'b1;
        tick();
        check_eq("drop_xfer_valid", out_valid, 0);
        ticks(254);
        check_eq("drop_no_early_valid", out_valid, 0);
        tick();
        check_eq("drop_new_valid", out_valid, 1);
        check_eq("drop_new_duty", duty, 255);
        check_eq("drop_new_edges", edges, 0);

        // Asynchronous reset with valid and overrun set
        do_reset();
        cmp_in    = 1'b1;
        out_ready = 1'b0;
        ticks(3);
        ena = 1'b1;
        ticks(560);
        check_eq("ar_pre_valid", out_valid, 1);
        check_eq("ar_pre_overrun", overrun, 1);
        check_eq("ar_pre_sync", cmp_sync, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", out_valid, 0);
        check_eq("ar_duty", duty, 0);
        check_eq("ar_edges", edges, 0);
        check_eq("ar_overrun", overrun, 0);
        check_eq("ar_sync", cmp_sync, 0);
        ena = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
